// File: rtl/aes_decrypt_iter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// aes_decrypt_iter_if : handshake/data bundle for aes_decrypt_iter
// (key_valid present only with AES_DEC_KEY_STALL_EN).  Rev 1.0
// ============================================================================
interface aes_decrypt_iter_if;
   logic         start;
   logic [127:0] cipher_in;
   logic [127:0] round_key;
   logic [3:0]   rk_idx;
   logic         busy;
   logic [127:0] plain_out;
   logic         done;
`ifdef AES_DEC_KEY_STALL_EN
   logic         key_valid;

   modport master (output start, cipher_in, round_key, key_valid,
                   input  rk_idx, busy, plain_out, done);
   modport slave  (input  start, cipher_in, round_key, key_valid,
                   output rk_idx, busy, plain_out, done);
`else
   modport master (output start, cipher_in, round_key,
                   input  rk_idx, busy, plain_out, done);
   modport slave  (input  start, cipher_in, round_key,
                   output rk_idx, busy, plain_out, done);
`endif
endinterface
`default_nettype wire

// File: rtl/aes_decrypt_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// aes_decrypt_iter : iterative AES-128 decryption, one round per clock.
// Optional macro AES_DEC_KEY_STALL_EN adds a key_valid stall qualifier. Rev 1.0
// ============================================================================
module aes_decrypt_iter (
   input  logic              clk,
   input  logic              rst,
   aes_decrypt_iter_if.slave bus
);
   localparam logic [0:2047] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

   fsm_t         fsm;
   logic [127:0] state;
   logic [3:0]   cnt;
   logic [3:0]   rk_reg;
   logic         busy_reg;
   logic         done_reg;
   logic [127:0] plain_reg;
   logic [127:0] shifted;
   logic [127:0] subbed;
   logic [127:0] added;
   logic [127:0] mixed;
   logic         key_ok;

   function automatic logic [7:0] inv_sub(input logic [7:0] b);
      return INV_SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // k is one of 9/b/d/e: sum of the selected a*2^n terms
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] a2;
      logic [7:0] a4;
      logic [7:0] a8;
      a2 = xt(a);
      a4 = xt(a2);
      a8 = xt(a4);
      return (k[0] ? a : 8'h00) ^ (k[1] ? a2 : 8'h00) ^
             (k[2] ? a4 : 8'h00) ^ (k[3] ? a8 : 8'h00);
   endfunction

`ifdef AES_DEC_KEY_STALL_EN
   assign key_ok = bus.key_valid;
`else
   assign key_ok = 1'b1;
`endif

   for (genvar i = 0; i < 16; i++) begin : g_byte
      localparam int SRC = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
      assign shifted[127-8*i -: 8] = state[127-8*SRC -: 8];
      assign subbed[127-8*i -: 8]  = inv_sub(shifted[127-8*i -: 8]);
   end

   assign added = subbed ^ bus.round_key;

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = added[127-32*c -: 8];
      assign a1 = added[119-32*c -: 8];
      assign a2 = added[111-32*c -: 8];
      assign a3 = added[103-32*c -: 8];
      assign mixed[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
      assign mixed[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
      assign mixed[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
      assign mixed[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         state     <= '0;
         cnt       <= 4'd0;
         rk_reg    <= 4'd10;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         plain_reg <= '0;
      end else begin
         case (fsm)
            IDLE: begin
               done_reg <= 1'b0;
               if (bus.start && key_ok) begin
                  state    <= bus.cipher_in ^ bus.round_key;
                  cnt      <= 4'd9;
                  rk_reg   <= 4'd9;
                  busy_reg <= 1'b1;
                  fsm      <= ROUND;
               end
            end
            ROUND: begin
               if (key_ok) begin
                  state <= mixed;
                  cnt   <= cnt - 4'd1;
                  // rk_idx leads the counter so the key arrives with the round
                  rk_reg <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     fsm <= FINAL;
                  end
               end
            end
            FINAL: begin
               if (key_ok) begin
                  plain_reg <= added;
                  done_reg  <= 1'b1;
                  fsm       <= DONE;
               end
            end
            DONE: begin
               done_reg <= 1'b0;
               busy_reg <= 1'b0;
               rk_reg   <= 4'd10;
               fsm      <= IDLE;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   assign bus.rk_idx    = rk_reg;
   assign bus.busy      = busy_reg;
   assign bus.done      = done_reg;
   assign bus.plain_out = plain_reg;

endmodule
`default_nettype wire
